display_mode_arbiter: RTL and testbench
=======================================

// Module: display_mode_arbiter
// PURPOSE
//  Shares the 7-seg display word and 16 LEDs between NUM_MODES mode controllers (predefined-sentence, typing, ...).
//  Grants exactly one mode at a time through one-hot mode_enable and muxes that mode's display and LED words to the outputs.
//  Routes keyboard scan codes to the granted mode only; F1-F4 scan codes select modes.
//  Inserts a blanking interval on every switch so no stale button or keyboard input leaks into the new mode.
//  Sits between the board-level input conditioning (debounced pulses, PS/2 decoder) and the per-mode controllers.
// PARAMETERS
//  NUM_MODES      4           number of requesters; fixed 2-bit mode index, so legal range is 2..4
//  BLANK_CYCLES   1_000_000   switch blanking length in clk cycles (10 ms at 100 MHz); must be >=1
//  BLANK_WORD     32'hFFFF_FFFF  display word driven while blanking (all segments off, active-low)
//  IDLE_TIMEOUT   6_000_000_000  cycles with no input before auto-return to mode 0 (only with DISP_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock, 100 MHz
//  reset_n      in   1            asynchronous, active-low reset
//  mode_req     in   NUM_MODES    one-cycle button pulses; bit i requests mode i
//  keyboard     in   8            scan code, valid in the cycle kb_valid is high
//  kb_valid     in   1            one-cycle strobe qualifying keyboard
//  disp_in      in   32*NUM_MODES display words, mode i at [32i+31:32i]
//  led_in       in   16*NUM_MODES LED words, mode i at [16i+15:16i]
//  mode_enable  out  NUM_MODES    one-hot grant; all zero while blanking
//  kb_out       out  8            forwarded scan code; 8'h00 when not forwarding
//  display_out  out  32           granted mode's display word, or BLANK_WORD
//  led_out      out  16           granted mode's LED word, or 16'h0000
//  current_mode out  2            index of the granted (or pending) mode
//  busy         out  1            high while in BLANK
// BEHAVIOUR
//  Reset: state ACTIVE, current_mode=0, mode_enable=0001, kb_out=0, outputs follow mode 0.
//  States: ACTIVE (grant held) and BLANK (counting down, no grant).
//  Request source: mode_req bit i, or kb_valid with scan code 05/06/04/0C (F1/F2/F3/F4 -> mode 0/1/2/3).
//    A hotkey for a mode index >= NUM_MODES is ignored and not forwarded.
//    Simultaneous requests: lowest index wins; a button and a hotkey in the same cycle are merged before priority.
//  ACTIVE:
//    Request for a different mode -> next cycle: BLANK, mode_enable=0, current_mode=new, counter=BLANK_CYCLES-1.
//    Request for the current mode is ignored.
//    Non-hotkey scan codes are registered to kb_out for exactly 1 cycle (1-cycle latency); hotkeys are never forwarded.
//  BLANK:
//    display_out=BLANK_WORD, led_out=0, kb_out=0, busy=1.
//    A new different request retargets current_mode and restarts the counter.
//    When the counter reaches 0 -> ACTIVE; mode_enable=onehot(current_mode) from the next cycle.
//  Output mux is registered: display_out and led_out lag disp_in and led_in by 1 cycle.
//  Async reset mid-BLANK aborts the switch immediately and returns to mode 0.
// CONFIGURATION
//  DISP_ARB_TIMEOUT_EN defined:
//    An idle counter clears on any mode_req or kb_valid.
//    After IDLE_TIMEOUT idle cycles in ACTIVE with current_mode!=0, a switch to mode 0 is issued through BLANK.
//  DISP_ARB_TIMEOUT_EN undefined: no idle counter; the grant persists until requested otherwise.
// STRUCTURE
//  Package display_pkg:
//    arb_state_t enum {ACTIVE, BLANK}
//    SC_F1..SC_F4 scan-code constants
//    SEG_BLANK constant
//  Sub-module blank_timer:
//    loadable down-counter (load, load_val, zero flag), shared by the blanking count and the idle timeout.
// TESTING
//  1. Reset -> mode_enable=0001, busy=0, display_out=disp_in[31:0] one cycle later.
//  2. mode_req=0100 pulse (BLANK_CYCLES=8) -> busy=1 for 8 cycles, display_out=FFFF_FFFF, then mode_enable=0100.
//  3. mode_req=0110 in one cycle -> mode 1 granted; in BLANK, a mode_req=1000 pulse retargets to 3 and restarts the 8-cycle count.
//  4. Mode 1 active, kb 8'h74 -> kb_out=74 for 1 cycle; kb 8'h06 (F2, current mode) -> ignored, kb_out=0.
//  5. Mode 0 active, kb 8'h04 (F3) with NUM_MODES=2 -> ignored; kb 8'h74 during BLANK -> kb_out stays 0.
//  6. Timeout build, IDLE_TIMEOUT=20, in mode 2 -> after 20 idle cycles busy rises, then mode_enable=0001; reset_n low mid-BLANK -> mode 0 at once.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display mode arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    // The grant is either held (ACTIVE) or withdrawn while a switch settles (BLANK).
    typedef enum logic {
        ACTIVE = 1'b0,
        BLANK  = 1'b1
    } arb_state_t;

    // PS/2 set-2 make codes of the function keys used as mode hotkeys.
    localparam logic [7:0] SC_F1 = 8'h05;
    localparam logic [7:0] SC_F2 = 8'h06;
    localparam logic [7:0] SC_F3 = 8'h04;
    localparam logic [7:0] SC_F4 = 8'h0C;

    // Active-low segments: all ones turns every segment off.
    localparam logic [31:0] SEG_BLANK = 32'hFFFF_FFFF;
    localparam logic [15:0] LED_OFF   = 16'h0000;

    // Returns {is_hotkey, mode_index}; the index is meaningless when is_hotkey is 0.
    function automatic logic [2:0] decode_hotkey(input logic [7:0] sc);
        logic [2:0] res;
        res = 3'b000;
        case (sc)
            SC_F1:   res = 3'b100;
            SC_F2:   res = 3'b101;
            SC_F3:   res = 3'b110;
            SC_F4:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/display_mode_arbiter_blank_timer.sv
// Loadable down-counter that parks at zero; used for switch blanking and idle timeout.
// Latency: load takes effect on the next edge; zero is a combinational decode of the count.
// Backpressure: none; load always wins over counting.
module blank_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/display_mode_arbiter.sv
// Grants the 7-seg/LED outputs and keyboard stream to one of NUM_MODES mode controllers,
// with a blanking interval on every switch. Optional idle auto-return under DISP_ARB_TIMEOUT_EN.
// Latency: outputs and kb_out registered (1 cycle). Backpressure: none; requests during blanking retarget.
module display_mode_arbiter
    import display_pkg::*;
#(
    parameter int          NUM_MODES    = 4,
    parameter int          BLANK_CYCLES = 1_000_000,
    parameter logic [31:0] BLANK_WORD   = SEG_BLANK
`ifdef DISP_ARB_TIMEOUT_EN
    ,
    parameter longint unsigned IDLE_TIMEOUT = 64'd6_000_000_000
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MODES-1:0]   mode_req,
    input  logic [7:0]             keyboard,
    input  logic                   kb_valid,
    input  logic [32*NUM_MODES-1:0] disp_in,
    input  logic [16*NUM_MODES-1:0] led_in,
    output logic [NUM_MODES-1:0]   mode_enable,
    output logic [7:0]             kb_out,
    output logic [31:0]            display_out,
    output logic [15:0]            led_out,
    output logic [1:0]             current_mode,
    output logic                   busy
);

    // The counter is loaded with BLANK_CYCLES-1 and the zero cycle is still blank,
    // so exactly BLANK_CYCLES blank cycles are seen.
    localparam int             BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0]  BLANK_LOAD = BW'(BLANK_CYCLES - 1);

    arb_state_t           state_q, state_nxt;
    logic [1:0]           mode_q, mode_nxt;
    logic [7:0]           kb_q, kb_nxt;
    logic [31:0]          disp_q, disp_nxt;
    logic [15:0]          led_q, led_nxt;

    logic [2:0]           hk_dec;
    logic                 hk_hit;
    logic [1:0]           hk_idx;
    logic [NUM_MODES-1:0] hk_vec;
    logic [NUM_MODES-1:0] req_vec;
    logic                 req_any;
    logic [1:0]           req_idx;

    logic                 blank_load;
    logic                 blank_zero;
    logic                 timeout_fire;

    // Turn a function-key scan code into a request bit; keys beyond NUM_MODES map to nothing.
    always_comb begin
        hk_dec = decode_hotkey(keyboard);
        hk_hit = kb_valid && hk_dec[2];
        hk_idx = hk_dec[1:0];
        hk_vec = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            hk_vec[i] = hk_hit && (hk_idx == 2'(i));
        end
    end

    // Merge buttons, hotkeys and the idle timeout, then pick the lowest requested index.
    always_comb begin
        req_vec    = mode_req | hk_vec;
        req_vec[0] = req_vec[0] | timeout_fire;
        req_any    = |req_vec;
        req_idx    = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                req_idx = 2'(i);
            end
        end
    end

    // Next-state logic: any request for a mode other than the current/pending one (re)starts blanking.
    always_comb begin
        state_nxt  = state_q;
        mode_nxt   = mode_q;
        blank_load = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (req_any && (req_idx != mode_q)) begin
                    state_nxt  = BLANK;
                    mode_nxt   = req_idx;
                    blank_load = 1'b1;
                end
            end
            BLANK: begin
                if (req_any && (req_idx != mode_q)) begin
                    mode_nxt   = req_idx;
                    blank_load = 1'b1;
                end else if (blank_zero) begin
                    state_nxt = ACTIVE;
                end
            end
            default: begin
                state_nxt = ACTIVE;
                mode_nxt  = '0;
            end
        endcase
    end

    // Output mux is evaluated against the next state so registered outputs line up with the grant.
    always_comb begin
        kb_nxt   = '0;
        disp_nxt = BLANK_WORD;
        led_nxt  = LED_OFF;
        // Forward only ordinary scan codes, and only when the grant survives this cycle.
        if ((state_q == ACTIVE) && (state_nxt == ACTIVE) && kb_valid && !hk_dec[2]) begin
            kb_nxt = keyboard;
        end
        if (state_nxt == ACTIVE) begin
            disp_nxt = disp_in[32*int'(mode_nxt) +: 32];
            led_nxt  = led_in[16*int'(mode_nxt) +: 16];
        end
    end

    // State, mode index and registered outputs; reset lands straight in mode 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACTIVE;
            mode_q  <= '0;
            kb_q    <= '0;
            disp_q  <= BLANK_WORD;
            led_q   <= LED_OFF;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            kb_q    <= kb_nxt;
            disp_q  <= disp_nxt;
            led_q   <= led_nxt;
        end
    end

    // One-hot grant derived from the state register; all zero while blanking.
    always_comb begin
        mode_enable = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            mode_enable[i] = (state_q == ACTIVE) && (mode_q == 2'(i));
        end
    end

    assign kb_out       = kb_q;
    assign display_out  = disp_q;
    assign led_out      = led_q;
    assign current_mode = mode_q;
    assign busy         = (state_q == BLANK);

    blank_timer #(
        .W(BW)
    ) u_blank_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (blank_load),
        .load_val (BLANK_LOAD),
        .zero     (blank_zero)
    );

`ifdef DISP_ARB_TIMEOUT_EN
    localparam int            IW        = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_TIMEOUT - 1);

    logic any_input;
    logic idle_armed;
    logic idle_load;
    logic idle_zero;

    // Idle count only runs while a non-default mode holds the grant; any input rearms it.
    always_comb begin
        any_input    = (|mode_req) || kb_valid;
        idle_armed   = (state_q == ACTIVE) && (mode_q != 2'd0);
        idle_load    = any_input || !idle_armed;
        timeout_fire = idle_armed && idle_zero && !any_input;
    end

    blank_timer #(
        .W(IW)
    ) u_idle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (idle_load),
        .load_val (IDLE_LOAD),
        .zero     (idle_zero)
    );
`else
    assign timeout_fire = 1'b0;
`endif

endmodule

// File: tb/tb_display_mode_arbiter.sv
// Scoreboard bench for display_mode_arbiter: directed stimulus pushes expected states per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
// Uses a 4-mode and a 2-mode instance, plus a short-timeout instance under DISP_ARB_TIMEOUT_EN.
module tb_display_mode_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4-mode instance
    logic [3:0]   a_req;
    logic [7:0]   a_kb;
    logic         a_kbv;
    logic [127:0] a_disp;
    logic [63:0]  a_led;
    logic [3:0]   a_me;
    logic [7:0]   a_kbo;
    logic [31:0]  a_dout;
    logic [15:0]  a_lout;
    logic [1:0]   a_cm;
    logic         a_busy;

    // 2-mode instance
    logic [1:0]   b_req;
    logic [7:0]   b_kb;
    logic         b_kbv;
    logic [63:0]  b_disp;
    logic [31:0]  b_led;
    logic [1:0]   b_me;
    logic [7:0]   b_kbo;
    logic [31:0]  b_dout;
    logic [15:0]  b_lout;
    logic [1:0]   b_cm;
    logic         b_busy;

    display_mode_arbiter #(.NUM_MODES(4), .BLANK_CYCLES(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .mode_req(a_req), .keyboard(a_kb), .kb_valid(a_kbv),
        .disp_in(a_disp), .led_in(a_led), .mode_enable(a_me), .kb_out(a_kbo),
        .display_out(a_dout), .led_out(a_lout), .current_mode(a_cm), .busy(a_busy));

    display_mode_arbiter #(.NUM_MODES(2), .BLANK_CYCLES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .mode_req(b_req), .keyboard(b_kb), .kb_valid(b_kbv),
        .disp_in(b_disp), .led_in(b_led), .mode_enable(b_me), .kb_out(b_kbo),
        .display_out(b_dout), .led_out(b_lout), .current_mode(b_cm), .busy(b_busy));

`ifdef DISP_ARB_TIMEOUT_EN
    logic [3:0]   c_req;
    logic [3:0]   c_me;
    logic [7:0]   c_kbo;
    logic [31:0]  c_dout;
    logic [15:0]  c_lout;
    logic [1:0]   c_cm;
    logic         c_busy;

    display_mode_arbiter #(.NUM_MODES(4), .BLANK_CYCLES(8), .IDLE_TIMEOUT(20)) dut_c (
        .clk(clk), .reset_n(reset_n), .mode_req(c_req), .keyboard(8'h00), .kb_valid(1'b0),
        .disp_in(a_disp), .led_in(a_led), .mode_enable(c_me), .kb_out(c_kbo),
        .display_out(c_dout), .led_out(c_lout), .current_mode(c_cm), .busy(c_busy));
`endif

    function automatic logic [31:0] dw(input int i);
        return 32'h1234_5600 | 32'(i);
    endfunction

    function automatic logic [15:0] lw(input int i);
        return 16'hBE00 | 16'(i);
    endfunction

    typedef struct {
        int           cyc;
        int           sel;
        logic [127:0] name;
        logic [3:0]   me;
        logic         busy;
        logic [1:0]   cm;
        logic [7:0]   kb;
        logic         chk_dl;
        logic [31:0]  disp;
        logic [15:0]  led;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Push an expectation with explicit display/LED words.
    task automatic expect_raw(input int off, input int sel, input logic [127:0] nm,
                              input logic [3:0] me, input logic bz, input logic [1:0] cm,
                              input logic [7:0] kb, input logic chk_dl,
                              input logic [31:0] d, input logic [15:0] l);
        exp_t e;
        e.cyc = cyc + off; e.sel = sel; e.name = nm; e.me = me; e.busy = bz;
        e.cm = cm; e.kb = kb; e.chk_dl = chk_dl; e.disp = d; e.led = l;
        sbq.push_back(e);
    endtask

    // Push an expectation whose display/LED words follow from the grant: blank words while busy.
    task automatic expect_st(input int off, input int sel, input logic [127:0] nm,
                             input logic [3:0] me, input logic bz, input logic [1:0] cm,
                             input logic [7:0] kb, input logic chk_dl);
        expect_raw(off, sel, nm, me, bz, cm, kb, chk_dl,
                   bz ? 32'hFFFF_FFFF : dw(int'(cm)), bz ? 16'h0000 : lw(int'(cm)));
    endtask

    task automatic compare(input exp_t e);
        logic [3:0]  me;
        logic        bz;
        logic [1:0]  cm;
        logic [7:0]  kb;
        logic [31:0] d;
        logic [15:0] l;
        me = 'x; bz = 'x; cm = 'x; kb = 'x; d = 'x; l = 'x;
        case (e.sel)
            0: begin me = a_me; bz = a_busy; cm = a_cm; kb = a_kbo; d = a_dout; l = a_lout; end
            1: begin me = {2'b00, b_me}; bz = b_busy; cm = b_cm; kb = b_kbo; d = b_dout; l = b_lout; end
`ifdef DISP_ARB_TIMEOUT_EN
            2: begin me = c_me; bz = c_busy; cm = c_cm; kb = c_kbo; d = c_dout; l = c_lout; end
`endif
            default: ;
        endcase
        checks++;
        if (me !== e.me || bz !== e.busy || cm !== e.cm || kb !== e.kb ||
            (e.chk_dl && (d !== e.disp || l !== e.led))) begin
            errors++;
            $display("FAIL %0s @%0d: got me=%b busy=%b cm=%0d kb=%h disp=%h led=%h; want me=%b busy=%b cm=%0d kb=%h disp=%h led=%h (disp/led checked=%0b)",
                     e.name, cyc, me, bz, cm, kb, d, l, e.me, e.busy, e.cm, e.kb, e.disp, e.led, e.chk_dl);
        end
    endtask

    // Monitor: compare every expectation due this cycle; anything overdue is a failure.
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %0s: expectation for cycle %0d never compared", sbq[k].name, sbq[k].cyc);
                sbq.delete(k);
            end else if (sbq[k].cyc == cyc) begin
                compare(sbq[k]);
                sbq.delete(k);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = '0; a_kb = '0; a_kbv = 1'b0;
        b_req = '0; b_kb = '0; b_kbv = 1'b0;
`ifdef DISP_ARB_TIMEOUT_EN
        c_req = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            a_disp[32*i +: 32] = dw(i);
            a_led[16*i +: 16]  = lw(i);
        end
        for (int i = 0; i < 2; i++) begin
            b_disp[32*i +: 32] = dw(i);
            b_led[16*i +: 16]  = lw(i);
        end

        // Reset state, then mode 0 words one cycle after release
        step(2);
        expect_st(0, 0, "rst_a", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
        expect_st(0, 1, "rst_b", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
        step(1);
        reset_n = 1'b1;
        expect_st(1, 0, "rst_follow_a", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
        expect_st(1, 1, "rst_follow_b", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
        step(2);

        // Switch to mode 2: eight blank cycles, then grant
        a_req = 4'b0100;
        expect_st(1, 0, "sw2_first", 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1);
        expect_st(8, 0, "sw2_last", 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1);
        expect_st(9, 0, "sw2_grant", 4'b0100, 1'b0, 2'd2, 8'h00, 1'b1);
        step(1); a_req = '0; step(9);

        // Two buttons at once: lowest index (1) wins
        a_req = 4'b0110;
        expect_st(1, 0, "dual_req", 4'b0000, 1'b1, 2'd1, 8'h00, 1'b1);
        expect_st(9, 0, "dual_grant", 4'b0010, 1'b0, 2'd1, 8'h00, 1'b1);
        step(1); a_req = '0; step(9);

        // Ordinary scan code forwarded for exactly one cycle
        a_kb = 8'h74; a_kbv = 1'b1;
        expect_st(1, 0, "kb_fwd", 4'b0010, 1'b0, 2'd1, 8'h74, 1'b1);
        expect_st(2, 0, "kb_one_cycle", 4'b0010, 1'b0, 2'd1, 8'h00, 1'b1);
        step(1); a_kbv = 1'b0; step(1);

        // F2 while in mode 1: ignored and not forwarded
        a_kb = 8'h06; a_kbv = 1'b1;
        expect_st(1, 0, "f2_same_mode", 4'b0010, 1'b0, 2'd1, 8'h00, 1'b1);
        step(1); a_kbv = 1'b0; step(2);

        // F4 hotkey switches to mode 3
        a_kb = 8'h0C; a_kbv = 1'b1;
        expect_st(1, 0, "f4_switch", 4'b0000, 1'b1, 2'd3, 8'h00, 1'b1);
        expect_st(9, 0, "f4_grant", 4'b1000, 1'b0, 2'd3, 8'h00, 1'b1);
        step(1); a_kbv = 1'b0; step(9);

        // Request for the current mode is ignored
        a_req = 4'b1000;
        expect_st(1, 0, "same_req", 4'b1000, 1'b0, 2'd3, 8'h00, 1'b1);
        step(1); a_req = '0; step(1);

        // Registered mux: a new word for mode 3 appears one cycle later
        a_disp[96 +: 32] = 32'hCAFE_F00D;
        a_led[48 +: 16]  = 16'h5A5A;
        expect_raw(0, 0, "lag_old", 4'b1000, 1'b0, 2'd3, 8'h00, 1'b1, dw(3), lw(3));
        expect_raw(1, 0, "lag_new", 4'b1000, 1'b0, 2'd3, 8'h00, 1'b1, 32'hCAFE_F00D, 16'h5A5A);
        step(1);
        a_disp[96 +: 32] = dw(3);
        a_led[48 +: 16]  = lw(3);
        step(2);

        // Button 3 and F3 hotkey together: merged, mode 2 wins
        a_req = 4'b1000; a_kb = 8'h04; a_kbv = 1'b1;
        expect_st(1, 0, "merge_req", 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1);
        expect_st(9, 0, "merge_grant", 4'b0100, 1'b0, 2'd2, 8'h00, 1'b1);
        step(1); a_req = '0; a_kbv = 1'b0; step(9);

        // Retarget during blanking restarts the count; keyboard stays muted while blanking
        a_req = 4'b0001;
        expect_st(1, 0, "rt_start", 4'b0000, 1'b1, 2'd0, 8'h00, 1'b1);
        step(1); a_req = '0; step(1);
        a_kb = 8'h74; a_kbv = 1'b1;
        expect_st(1, 0, "kb_in_blank", 4'b0000, 1'b1, 2'd0, 8'h00, 1'b1);
        step(1); a_kbv = 1'b0;
        a_req = 4'b1000;
        expect_st(1, 0, "rt_target", 4'b0000, 1'b1, 2'd3, 8'h00, 1'b1);
        expect_st(8, 0, "rt_restarted", 4'b0000, 1'b1, 2'd3, 8'h00, 1'b1);
        expect_st(9, 0, "rt_grant", 4'b1000, 1'b0, 2'd3, 8'h00, 1'b1);
        step(1); a_req = '0; step(9);

        // 2-mode instance: F3 is out of range, F2 is honoured, ordinary code forwarded
        b_kb = 8'h04; b_kbv = 1'b1;
        expect_st(1, 1, "b_f3_ignored", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
        step(1); b_kbv = 1'b0; step(1);
        b_kb = 8'h1C; b_kbv = 1'b1;
        expect_st(1, 1, "b_kb_fwd", 4'b0001, 1'b0, 2'd0, 8'h1C, 1'b1);
        step(1); b_kbv = 1'b0; step(1);
        b_kb = 8'h06; b_kbv = 1'b1;
        expect_st(1, 1, "b_f2_switch", 4'b0000, 1'b1, 2'd1, 8'h00, 1'b1);
        expect_st(4, 1, "b_blank_last", 4'b0000, 1'b1, 2'd1, 8'h00, 1'b1);
        expect_st(5, 1, "b_grant", 4'b0010, 1'b0, 2'd1, 8'h00, 1'b1);
        step(1); b_kbv = 1'b0; step(6);

`ifdef DISP_ARB_TIMEOUT_EN
        // Idle auto-return: 20 idle cycles in mode 2, then blank back to mode 0
        c_req = 4'b0100;
        expect_st(1, 2, "c_sw2", 4'b0000, 1'b1, 2'd2, 8'h00, 1'b1);
        expect_st(9, 2, "c_grant2", 4'b0100, 1'b0, 2'd2, 8'h00, 1'b1);
        expect_st(28, 2, "c_idle_hold", 4'b0100, 1'b0, 2'd2, 8'h00, 1'b1);
        expect_st(29, 2, "c_timeout", 4'b0000, 1'b1, 2'd0, 8'h00, 1'b1);
        expect_st(38, 2, "c_home", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
        step(1); c_req = '0; step(40);
`endif

        // Asynchronous reset in the middle of blanking returns to mode 0 immediately
        a_req = 4'b0010;
        expect_st(1, 0, "pre_rst_blank", 4'b0000, 1'b1, 2'd1, 8'h00, 1'b1);
        step(1); a_req = '0; step(2);
        #2;
        reset_n = 1'b0;
        expect_st(0, 0, "rst_mid_blank", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
        expect_st(0, 1, "rst_mid_b", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0);
        step(2);
        reset_n = 1'b1;
        expect_st(1, 0, "post_rst", 4'b0001, 1'b0, 2'd0, 8'h00, 1'b1);
        step(4);

        while (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %0s: expectation for cycle %0d left unchecked", sbq[0].name, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
